// File: rtl/approx_booth_seq_mult.sv
// Sequential radix-4 Booth multiplier with optional LSB truncation of the low-order
// partial products (approximate DNN MAC datapath). One Booth group is retired per cycle.
// Optional feature macro: APPROX_ERR_OUT_EN adds an err output (exact product - p)
// backed by an exact accumulator running in parallel.
// WIDTH must be even and >= 4.
module approx_booth_seq_mult #(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned APPROX_GROUPS = WIDTH / 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 approx_en,
   output logic                 out_valid,
   input  logic                 out_ready,
`ifdef APPROX_ERR_OUT_EN
   output logic [2*WIDTH-1:0]   err,
`endif
   output logic [2*WIDTH-1:0]   p
);

   localparam int unsigned PW     = 2 * WIDTH;
   localparam int unsigned Groups = WIDTH / 2;
   localparam int unsigned CntW   = $clog2(Groups);

   localparam logic [CntW-1:0] LastCnt = CntW'(Groups - 1);
   localparam logic [PW-1:0]   LsbMask = {{(PW-1){1'b1}}, 1'b0};
   localparam logic [PW-1:0]   Col1    = {{(PW-2){1'b0}}, 2'b10};

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_r_q, a_r_d;
   // Multiplier shifted right two bits per group; bit 0 holds b[2i-1] (b[-1]=0 initially).
   logic [WIDTH:0]    b_r_q, b_r_d;
   logic              approx_q, approx_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [PW-1:0]     p_q, p_d;
`ifdef APPROX_ERR_OUT_EN
   logic [PW-1:0]     ex_acc_q, ex_acc_d;
   logic [PW-1:0]     err_q, err_d;
`endif

   logic [2:0]        group;
   logic              sel, is2, neg;
   logic              approx_grp;
   logic              corr;
   logic [PW-1:0]     a_ext, mag, ones;
   logic [PW-1:0]     pp_apx, pp_exact, pp_sel;
   logic [PW-1:0]     pp_w, pp_exact_w;
   logic [CntW:0]     shamt;
   logic [PW-1:0]     acc_sum;
   logic [PW-1:0]     ex_sum;

   // Correction carry for a truncated group: replaces the negation +1 at column 2i with a
   // carry into column 2i+1 whenever the discarded LSB of the complete PP would be 0.
   function automatic logic corr_bit(input logic [2:0] bin, input logic alsb);
      logic n;
      logic one;
      n   = (bin == 3'b100) || (bin == 3'b101) || (bin == 3'b110);
      one = (bin == 3'b101) || (bin == 3'b110);
      return n & ~(one & alsb);
   endfunction

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (in_valid) state_d = StRun;
         StRun:   if (cnt_q == LastCnt) state_d = StDone;
         StDone:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      in_ready  = (state_q == StIdle);
      out_valid = (state_q == StDone);
   end

   // Booth digit decode of the current group
   always_comb begin
      group = b_r_q[2:0];
      sel   = 1'b0;
      is2   = 1'b0;
      neg   = 1'b0;
      case (group)
         3'b001, 3'b010: sel = 1'b1;
         3'b011: begin
            sel = 1'b1;
            is2 = 1'b1;
         end
         3'b100: begin
            sel = 1'b1;
            is2 = 1'b1;
            neg = 1'b1;
         end
         3'b101, 3'b110: begin
            sel = 1'b1;
            neg = 1'b1;
         end
         default: sel = 1'b0;
      endcase
   end

   // Partial product formation (exact and truncated) and weighting by 2^(2i)
   always_comb begin
      a_ext      = {{WIDTH{a_r_q[WIDTH-1]}}, a_r_q};
      mag        = is2 ? (a_ext << 1) : a_ext;
      ones       = sel ? (neg ? ~mag : mag) : '0;
      pp_exact   = ones + {{(PW-1){1'b0}}, neg};
      corr       = corr_bit(group, a_r_q[0]);
      pp_apx     = (ones & LsbMask) + (corr ? Col1 : '0);
      approx_grp = approx_q && (32'(cnt_q) < APPROX_GROUPS);
      pp_sel     = approx_grp ? pp_apx : pp_exact;
      shamt      = {cnt_q, 1'b0};
      pp_w       = pp_sel << shamt;
      pp_exact_w = pp_exact << shamt;
      acc_sum    = acc_q + pp_w;
   end

   // Datapath next-state: capture on accept, accumulate in RUN, publish on last group
   always_comb begin
      a_r_d    = a_r_q;
      b_r_d    = b_r_q;
      approx_d = approx_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      p_d      = p_q;
`ifdef APPROX_ERR_OUT_EN
      ex_acc_d = ex_acc_q;
      err_d    = err_q;
      ex_sum   = ex_acc_q + pp_exact_w;
`else
      ex_sum   = pp_exact_w;
`endif
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_r_d    = a;
               b_r_d    = {b, 1'b0};
               approx_d = approx_en;
               cnt_d    = '0;
               acc_d    = '0;
`ifdef APPROX_ERR_OUT_EN
               ex_acc_d = '0;
`endif
            end
         end
         StRun: begin
            acc_d = acc_sum;
            b_r_d = b_r_q >> 2;
            cnt_d = cnt_q + 1'b1;
`ifdef APPROX_ERR_OUT_EN
            ex_acc_d = ex_sum;
`endif
            if (cnt_q == LastCnt) begin
               p_d = acc_sum;
`ifdef APPROX_ERR_OUT_EN
               err_d = ex_sum - acc_sum;
`endif
            end
         end
         StDone: begin
            p_d = p_q;
         end
         default: begin
            cnt_d = '0;
         end
      endcase
   end

   // Datapath registers; reset abandons any transaction in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r_q    <= '0;
         b_r_q    <= '0;
         approx_q <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         p_q      <= '0;
`ifdef APPROX_ERR_OUT_EN
         ex_acc_q <= '0;
         err_q    <= '0;
`endif
      end else begin
         a_r_q    <= a_r_d;
         b_r_q    <= b_r_d;
         approx_q <= approx_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         p_q      <= p_d;
`ifdef APPROX_ERR_OUT_EN
         ex_acc_q <= ex_acc_d;
         err_q    <= err_d;
`endif
      end
   end

   assign p = p_q;
`ifdef APPROX_ERR_OUT_EN
   assign err = err_q;
`endif

endmodule

// File: tb/tb_approx_booth_seq_mult.sv
// Self-checking bench for approx_booth_seq_mult: two instances (APPROX_GROUPS = 4 and 2)
// driven with shared stimulus; expected products are queued at accept and popped at output.
module tb_approx_booth_seq_mult;

   localparam int W  = 8;
   localparam int PW = 2 * W;
   localparam int NG = W / 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          approx_en;
   logic          out_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          in_ready4, in_ready2;
   logic          out_valid4, out_valid2;
   logic [PW-1:0] p4, p2;
`ifdef APPROX_ERR_OUT_EN
   logic [PW-1:0] err4, err2;
`endif

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   logic [PW-1:0] exp4_q[$];
   logic [PW-1:0] exp2_q[$];

   always #5 clk = ~clk;

   approx_booth_seq_mult #(.WIDTH(W)) dut4 (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready4),
      .a        (a),
      .b        (b),
      .approx_en(approx_en),
      .out_valid(out_valid4),
      .out_ready(out_ready),
`ifdef APPROX_ERR_OUT_EN
      .err      (err4),
`endif
      .p        (p4)
   );

   approx_booth_seq_mult #(.WIDTH(W), .APPROX_GROUPS(2)) dut2 (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready2),
      .a        (a),
      .b        (b),
      .approx_en(approx_en),
      .out_valid(out_valid2),
      .out_ready(out_ready),
`ifdef APPROX_ERR_OUT_EN
      .err      (err2),
`endif
      .p        (p2)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // p = a*b - sum over truncated groups with an odd digit (b[2i] != b[2i-1]) of a[0]*4^i
   function automatic logic [PW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic map, input int ag);
      logic signed [PW-1:0] ea, eb, prod;
      logic [PW-1:0]        corr;
      logic                 bm;
      ea   = {{W{ma[W-1]}}, ma};
      eb   = {{W{mb[W-1]}}, mb};
      prod = ea * eb;
      corr = '0;
      for (int i = 0; i < ag; i++) begin
         bm = 1'b0;
         if (i > 0) bm = mb[2*i-1];
         if (map && ma[0] && (mb[2*i] ^ bm)) corr = corr + (PW'(1) << (2 * i));
      end
      return prod - corr;
   endfunction

   // Drive one operand set from IDLE, wait for out_valid, check latency and products.
   // Returns at a falling edge in DONE with out_ready still low.
   task automatic start_and_wait(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tap, input logic use_k, input logic [PW-1:0] kexp);
      int            n;
      logic [PW-1:0] e4, e2;
      a         = ta;
      b         = tb;
      approx_en = tap;
      in_valid  = 1'b1;
      check("in_ready_at_start", 64'(in_ready4), 64'(1));
      exp4_q.push_back(model(ta, tb, tap, NG));
      exp2_q.push_back(model(ta, tb, tap, 2));
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid4 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("latency", 64'(n), 64'(NG));
      check("out_valid2", 64'(out_valid2), 64'(1));
      e4 = exp4_q.pop_front();
      e2 = exp2_q.pop_front();
      check("p_ag4", 64'(p4), 64'(e4));
      check("p_ag2", 64'(p2), 64'(e2));
      if (use_k) check("p_directed", 64'(p4), 64'(kexp));
`ifdef APPROX_ERR_OUT_EN
      check("err_ag4", 64'(err4), 64'(model(ta, tb, 1'b0, NG) - e4));
      check("err_ag2", 64'(err2), 64'(model(ta, tb, 1'b0, NG) - e2));
`endif
   endtask

   task automatic finish_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid_drop", 64'(out_valid4), 64'(0));
      check("in_ready_back", 64'(in_ready4), 64'(1));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      approx_en = 1'b0;
      a         = '0;
      b         = '0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 64'(in_ready4), 64'(1));
      check("rst_out_valid", 64'(out_valid4), 64'(0));
      check("rst_p4", 64'(p4), 64'(0));
      check("rst_p2", 64'(p2), 64'(0));
      rst = 1'b0;
      @(negedge clk);

      // Exact 3 * -1 leaves a nonzero p for the mid-run reset to clear
      start_and_wait(8'd3, 8'hFF, 1'b0, 1'b1, 16'hFFFD);
      finish_out();

      // Reset two cycles into RUN abandons the transaction
      a        = 8'd5;
      b        = 8'd6;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrst_in_ready", 64'(in_ready4), 64'(1));
      check("midrst_out_valid", 64'(out_valid4), 64'(0));
      check("midrst_p", 64'(p4), 64'(0));
      exp4_q.delete();
      exp2_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      start_and_wait(8'd5, 8'd6, 1'b0, 1'b1, 16'd30);
      finish_out();

      start_and_wait(8'd3, 8'hFF, 1'b1, 1'b1, 16'hFFFC);
      finish_out();
      start_and_wait(8'd7, 8'd1, 1'b1, 1'b1, 16'd6);
      finish_out();
      start_and_wait(8'd5, 8'd6, 1'b1, 1'b1, 16'd30);
      finish_out();
      start_and_wait(8'h80, 8'h80, 1'b1, 1'b1, 16'd16384);
      finish_out();
      start_and_wait(8'd0, 8'h80, 1'b1, 1'b1, 16'd0);
      finish_out();

      // Backpressure: out_ready low for 10 cycles with in_valid pulses that must be ignored
      start_and_wait(8'd7, 8'd1, 1'b1, 1'b1, 16'd6);
      for (int k = 0; k < 10; k++) begin
         in_valid = ((k % 2) == 0);
         a        = 8'($urandom);
         b        = 8'($urandom);
         @(negedge clk);
         check("bp_p", 64'(p4), 64'(6));
         check("bp_out_valid", 64'(out_valid4), 64'(1));
         check("bp_in_ready", 64'(in_ready4), 64'(0));
      end
      // Release together with in_valid: only the output handshake completes
      a         = 8'd5;
      b         = 8'd6;
      approx_en = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("overlap_out_valid", 64'(out_valid4), 64'(0));
      check("overlap_in_ready", 64'(in_ready4), 64'(1));
      check("overlap_p_held", 64'(p4), 64'(6));
      start_and_wait(8'd5, 8'd6, 1'b0, 1'b1, 16'd30);
      finish_out();

      // Back-to-back random transactions in both modes
      for (int t = 0; t < 1000; t++) begin
         start_and_wait(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 16'd0);
         finish_out();
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
